// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64I multi-lane decode stage with a 2-entry group skid FIFO
// Decodes NR_LANES instructions per fetch group, masks lanes after the first illegal one.

package C;
   localparam int XLEN = 64;

   typedef enum logic [5:0] {
      I_NOP,
      I_LUI, I_AUIPC, I_JAL, I_JALR,
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
      I_LB, I_LH, I_LW, I_LD, I_LBU, I_LHU, I_LWU,
      I_SB, I_SH, I_SW, I_SD,
      I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
      I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
      I_ADDIW, I_SLLIW, I_SRLIW, I_SRAIW,
      I_ADDW, I_SUBW, I_SLLW, I_SRLW, I_SRAW,
      I_FENCE, I_ECALL, I_EBREAK
   } op_e;

   typedef enum logic [2:0] {
      FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
   } fmt_e;

   typedef struct packed {
      op_e  op;
      fmt_e fmt;
   } fuop_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      fuop_t           fuop;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
   } si_t;
endpackage

module decode_stage #(
   parameter int NR_LANES = 2,
   parameter int CNT_W    = 64
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic [NR_LANES-1:0]                mask_i,
   input  logic [NR_LANES-1:0][C::XLEN-1:0]   pc_i,
   input  logic [NR_LANES-1:0][31:0]          data_i,
   output logic                               valid_o,
   input  logic                               ready_i,
   output C::si_t [NR_LANES-1:0]              si_o,
   output logic [NR_LANES-1:0]                illegal_o,
   output logic [CNT_W-1:0]                   decoded_cnt_o
);

   function automatic C::fuop_t dec_op(input logic [31:0] i);
      C::fuop_t f;
      f = '{C::I_NOP, C::FMT_NONE};
      casez (i)
         32'b?????????????????????????_0110111: f = '{C::I_LUI,    C::FMT_U};
         32'b?????????????????????????_0010111: f = '{C::I_AUIPC,  C::FMT_U};
         32'b?????????????????????????_1101111: f = '{C::I_JAL,    C::FMT_J};
         32'b?????????????????_000_?????_1100111: f = '{C::I_JALR,   C::FMT_I};
         32'b?????????????????_000_?????_1100011: f = '{C::I_BEQ,    C::FMT_B};
         32'b?????????????????_001_?????_1100011: f = '{C::I_BNE,    C::FMT_B};
         32'b?????????????????_100_?????_1100011: f = '{C::I_BLT,    C::FMT_B};
         32'b?????????????????_101_?????_1100011: f = '{C::I_BGE,    C::FMT_B};
         32'b?????????????????_110_?????_1100011: f = '{C::I_BLTU,   C::FMT_B};
         32'b?????????????????_111_?????_1100011: f = '{C::I_BGEU,   C::FMT_B};
         32'b?????????????????_000_?????_0000011: f = '{C::I_LB,     C::FMT_I};
         32'b?????????????????_001_?????_0000011: f = '{C::I_LH,     C::FMT_I};
         32'b?????????????????_010_?????_0000011: f = '{C::I_LW,     C::FMT_I};
         32'b?????????????????_011_?????_0000011: f = '{C::I_LD,     C::FMT_I};
         32'b?????????????????_100_?????_0000011: f = '{C::I_LBU,    C::FMT_I};
         32'b?????????????????_101_?????_0000011: f = '{C::I_LHU,    C::FMT_I};
         32'b?????????????????_110_?????_0000011: f = '{C::I_LWU,    C::FMT_I};
         32'b?????????????????_000_?????_0100011: f = '{C::I_SB,     C::FMT_S};
         32'b?????????????????_001_?????_0100011: f = '{C::I_SH,     C::FMT_S};
         32'b?????????????????_010_?????_0100011: f = '{C::I_SW,     C::FMT_S};
         32'b?????????????????_011_?????_0100011: f = '{C::I_SD,     C::FMT_S};
         32'b?????????????????_000_?????_0010011: f = '{C::I_ADDI,   C::FMT_I};
         32'b?????????????????_010_?????_0010011: f = '{C::I_SLTI,   C::FMT_I};
         32'b?????????????????_011_?????_0010011: f = '{C::I_SLTIU,  C::FMT_I};
         32'b?????????????????_100_?????_0010011: f = '{C::I_XORI,   C::FMT_I};
         32'b?????????????????_110_?????_0010011: f = '{C::I_ORI,    C::FMT_I};
         32'b?????????????????_111_?????_0010011: f = '{C::I_ANDI,   C::FMT_I};
         // RV64 immediate shifts carry a 6-bit shamt, so only funct6 is fixed
         32'b000000_??????_?????_001_?????_0010011: f = '{C::I_SLLI,  C::FMT_I};
         32'b000000_??????_?????_101_?????_0010011: f = '{C::I_SRLI,  C::FMT_I};
         32'b010000_??????_?????_101_?????_0010011: f = '{C::I_SRAI,  C::FMT_I};
         32'b0000000_?????_?????_000_?????_0110011: f = '{C::I_ADD,   C::FMT_R};
         32'b0100000_?????_?????_000_?????_0110011: f = '{C::I_SUB,   C::FMT_R};
         32'b0000000_?????_?????_001_?????_0110011: f = '{C::I_SLL,   C::FMT_R};
         32'b0000000_?????_?????_010_?????_0110011: f = '{C::I_SLT,   C::FMT_R};
         32'b0000000_?????_?????_011_?????_0110011: f = '{C::I_SLTU,  C::FMT_R};
         32'b0000000_?????_?????_100_?????_0110011: f = '{C::I_XOR,   C::FMT_R};
         32'b0000000_?????_?????_101_?????_0110011: f = '{C::I_SRL,   C::FMT_R};
         32'b0100000_?????_?????_101_?????_0110011: f = '{C::I_SRA,   C::FMT_R};
         32'b0000000_?????_?????_110_?????_0110011: f = '{C::I_OR,    C::FMT_R};
         32'b0000000_?????_?????_111_?????_0110011: f = '{C::I_AND,   C::FMT_R};
         32'b?????????????????_000_?????_0011011:   f = '{C::I_ADDIW, C::FMT_I};
         32'b0000000_?????_?????_001_?????_0011011: f = '{C::I_SLLIW, C::FMT_I};
         32'b0000000_?????_?????_101_?????_0011011: f = '{C::I_SRLIW, C::FMT_I};
         32'b0100000_?????_?????_101_?????_0011011: f = '{C::I_SRAIW, C::FMT_I};
         32'b0000000_?????_?????_000_?????_0111011: f = '{C::I_ADDW,  C::FMT_R};
         32'b0100000_?????_?????_000_?????_0111011: f = '{C::I_SUBW,  C::FMT_R};
         32'b0000000_?????_?????_001_?????_0111011: f = '{C::I_SLLW,  C::FMT_R};
         32'b0000000_?????_?????_101_?????_0111011: f = '{C::I_SRLW,  C::FMT_R};
         32'b0100000_?????_?????_101_?????_0111011: f = '{C::I_SRAW,  C::FMT_R};
         32'b?????????????????_000_?????_0001111:   f = '{C::I_FENCE, C::FMT_I};
         32'h00000073:                              f = '{C::I_ECALL,  C::FMT_NONE};
         32'h00100073:                              f = '{C::I_EBREAK, C::FMT_NONE};
         default:                                   f = '{C::I_NOP,    C::FMT_NONE};
      endcase
      return f;
   endfunction

   function automatic logic [C::XLEN-1:0] dec_imm(input logic [31:0] i, input C::fmt_e fmt);
      logic [C::XLEN-1:0] v;
      v = '0;
      case (fmt)
         C::FMT_I: v = {{(C::XLEN-12){i[31]}}, i[31:20]};
         C::FMT_S: v = {{(C::XLEN-12){i[31]}}, i[31:25], i[11:7]};
         C::FMT_B: v = {{(C::XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         C::FMT_U: v = {{(C::XLEN-32){i[31]}}, i[31:12], 12'b0};
         C::FMT_J: v = {{(C::XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:  v = '0;
      endcase
      return v;
   endfunction

   C::si_t [NR_LANES-1:0] w_grp_si;
   logic   [NR_LANES-1:0] w_grp_ill;
   C::si_t [NR_LANES-1:0] r_mem_si  [2];
   logic   [NR_LANES-1:0] r_mem_ill [2];
   logic                  r_wptr;
   logic                  r_rptr;
   logic   [1:0]          r_count;
   logic   [CNT_W-1:0]    r_cnt;
   logic                  w_push;
   logic                  w_pop;
   logic   [CNT_W-1:0]    w_head_pop;

   always_comb begin : lane_decode
      logic     v_trap;
      C::fuop_t v_fu;
      v_trap    = 1'b0;
      v_fu      = '{C::I_NOP, C::FMT_NONE};
      w_grp_si  = '0;
      w_grp_ill = '0;
      for (int l = 0; l < NR_LANES; l++) begin
         v_fu               = dec_op(data_i[l]);
         w_grp_si[l].pc     = pc_i[l];
         w_grp_si[l].fuop   = v_fu;
         w_grp_si[l].rs1    = data_i[l][19:15];
         w_grp_si[l].rs2    = data_i[l][24:20];
         w_grp_si[l].rd     = data_i[l][11:7];
         w_grp_si[l].imm    = dec_imm(data_i[l], v_fu.fmt);
         // Once a present lane traps, every younger lane in the group is squashed
         if (mask_i[l] && !v_trap) begin
            if (v_fu.op != C::I_NOP) begin
               w_grp_si[l].valid = 1'b1;
            end else begin
               w_grp_ill[l] = 1'b1;
               v_trap       = 1'b1;
            end
         end
      end
   end

   assign ready_o = (r_count < 2'd2);
   assign valid_o = (r_count != 2'd0);
   assign w_push  = valid_i & ready_o & ~flush_i;
   assign w_pop   = valid_o & ready_i & ~flush_i;

   always_comb begin
      w_head_pop = '0;
      for (int l = 0; l < NR_LANES; l++) begin
         w_head_pop = w_head_pop + CNT_W'(r_mem_si[r_rptr][l].valid);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_count <= 2'd0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_cnt   <= '0;
      end else if (flush_i) begin
         r_count <= 2'd0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
            r_cnt  <= r_cnt + w_head_pop;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage needs no reset; occupancy is tracked by r_count alone
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_si[r_wptr]  <= w_grp_si;
         r_mem_ill[r_wptr] <= w_grp_ill;
      end
   end

   assign si_o          = valid_o ? r_mem_si[r_rptr]  : '0;
   assign illegal_o     = valid_o ? r_mem_ill[r_rptr] : '0;
   assign decoded_cnt_o = r_cnt;

endmodule
